sr_ram_ctrl: RTL and testbench



---
 rtl/sr_ram_ctrl_pkg.sv | 24 ++
 rtl/sm_ram.sv | 24 ++
 rtl/sr_ram_ctrl.sv | 122 ++++++++++++
 tb/tb_sr_ram_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ram_ctrl_pkg.sv
// sr_ram_ctrl shared definitions: AGU opcodes,
// controller FSM states and the local-region decode.
package sr_ram_ctrl_pkg;

  localparam logic [2:0] AGU_IDLE  = 3'd0;
  localparam logic [2:0] AGU_LOAD  = 3'd1;
  localparam logic [2:0] AGU_STORE = 3'd2;

  localparam logic [2:0] RAMC_IDLE     = 3'd0;
  localparam logic [2:0] RAMC_LD_RESP  = 3'd1;
  localparam logic [2:0] RAMC_ST_ACK   = 3'd2;
  localparam logic [2:0] RAMC_EXT_REQ  = 3'd3;
  localparam logic [2:0] RAMC_EXT_WAIT = 3'd4;
  localparam logic [2:0] RAMC_EXT_RESP = 3'd5;

  // 33-bit compare so a 4 GiB local region cannot wrap
  function automatic logic is_local(
    input logic [31:0] addr,
    input int unsigned words
  );
    return {1'b0, addr} < (33'(words) << 2);
  endfunction

endpackage

// File: rtl/sm_ram.sv
// Single-port synchronous word RAM,
// registered read data with one-cycle latency.
module sm_ram #(
  parameter int WORDS = 1024,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sr_ram_ctrl.sv
// Per-core data-memory controller: local RAM or
// network adapter, with one-cycle completion pulses.
module sr_ram_ctrl
  import sr_ram_ctrl_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  aguInstructionOut,
  input  logic [31:0] ramAddress,
  input  logic [31:0] dataFromCpu,
  output logic [31:0] dataToCpu,
  output logic        dataReceived,
  output logic        instrTaken,
  output logic        ext_req_valid,
  input  logic        ext_req_ready,
  output logic        ext_req_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  output logic [7:0]  ext_src,
  input  logic        ext_resp_valid,
  input  logic [31:0] ext_resp_data
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        is_ld, is_st, loc;

  assign is_ld = aguInstructionOut == AGU_LOAD;
  assign is_st = aguInstructionOut == AGU_STORE;
  assign loc   = is_local(ramAddress, RAM_WORDS);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    ram_we  = 1'b0;
    unique case (state_q)
      RAMC_IDLE: begin
        if (is_ld || is_st) begin
          we_d    = is_st;
          addr_d  = ramAddress;
          wdata_d = dataFromCpu;
          if (loc) begin
            ram_we  = is_st;
            state_d = is_st ? RAMC_ST_ACK
                            : RAMC_LD_RESP;
          end else begin
            state_d = RAMC_EXT_REQ;
          end
        end
      end
      RAMC_EXT_REQ: begin
        if (ext_req_ready)
          state_d = we_q ? RAMC_ST_ACK
                         : RAMC_EXT_WAIT;
      end
      RAMC_EXT_WAIT: begin
        if (ext_resp_valid) begin
          resp_d  = ext_resp_data;
          state_d = RAMC_EXT_RESP;
        end
      end
      default: state_d = RAMC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RAMC_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end

  sm_ram #(
    .WORDS(RAM_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ramAddress[2 +: AW]),
    .wdata(dataFromCpu),
    .rdata(ram_rdata)
  );

  always_comb begin
    dataToCpu = '0;
    if (state_q == RAMC_LD_RESP)
      dataToCpu = ram_rdata;
    else if (state_q == RAMC_EXT_RESP)
      dataToCpu = resp_q;
  end

  assign dataReceived  = (state_q == RAMC_LD_RESP)
                      || (state_q == RAMC_EXT_RESP);
  assign instrTaken    = state_q == RAMC_ST_ACK;
  assign ext_req_valid = state_q == RAMC_EXT_REQ;
  assign ext_req_we    = we_q;
  assign ext_addr      = addr_q;
  assign ext_wdata     = wdata_q;
  assign ext_src       = 8'(NODE_ID);

endmodule

// File: tb/tb_sr_ram_ctrl.sv
// Bench for sr_ram_ctrl: scenario tasks plus a
// completion scoreboard checked on every pulse.
module tb_sr_ram_ctrl;
  import sr_ram_ctrl_pkg::*;

  localparam int NODE  = 90;
  localparam int WORDS = 1024;
  localparam logic [31:0] EXT_BASE = 32'(WORDS * 4);

  typedef struct {
    logic        ld;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  agu = AGU_IDLE;
  logic [31:0] addr = 32'hFFFF_FFFF;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        dr, it;
  logic        rq_v, rq_we;
  logic        rq_rdy = 1'b0;
  logic [31:0] rq_addr, rq_wdata;
  logic [7:0]  src;
  logic        rs_v = 1'b0;
  logic [31:0] rs_d = '0;

  int vectors = 0;
  int errors  = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  sr_ram_ctrl #(
    .NODE_ID  (NODE),
    .RAM_WORDS(WORDS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .aguInstructionOut(agu),
    .ramAddress       (addr),
    .dataFromCpu      (din),
    .dataToCpu        (dout),
    .dataReceived     (dr),
    .instrTaken       (it),
    .ext_req_valid    (rq_v),
    .ext_req_ready    (rq_rdy),
    .ext_req_we       (rq_we),
    .ext_addr         (rq_addr),
    .ext_wdata        (rq_wdata),
    .ext_src          (src),
    .ext_resp_valid   (rs_v),
    .ext_resp_data    (rs_d)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && (dr || it)) begin
      vectors++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected dr=%0b it=%0b data=%h",
                 dr, it, dout);
      end else begin
        mon_e = sb_q.pop_front();
        if (dr !== mon_e.ld || it !== !mon_e.ld ||
            (mon_e.ld && dout !== mon_e.data)) begin
          errors++;
          $display("FAIL sb_pulse got dr=%0b it=%0b data=%h exp ld=%0b data=%h",
                   dr, it, dout, mon_e.ld, mon_e.data);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] d);
    agu  = op;
    addr = a;
    din  = d;
  endtask

  task automatic go_idle();
    drive(AGU_IDLE, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic local_req(input bit ld,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [31:0] exp_d);
    logic p;
    @(posedge clk); #1;
    drive(ld ? AGU_LOAD : AGU_STORE, a, d);
    sb_q.push_back('{ld, exp_d});
    @(negedge clk);
    vectors++;
    if (dr !== 1'b0 || it !== 1'b0) begin
      errors++;
      $display("FAIL local_early a=%h dr=%0b it=%0b exp 0 0", a, dr, it);
    end
    @(negedge clk);
    p = ld ? dr : it;
    vectors++;
    if (p !== 1'b1) begin
      errors++;
      $display("FAIL local_latency a=%h ld=%0b pulse=%0b exp 1", a, ld, p);
    end
    go_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({dr, it, rq_v, rq_we} !== 4'b0 || dout !== '0 ||
        rq_addr !== '0 || rq_wdata !== '0) begin
      errors++;
      $display("FAIL reset_values got dr=%0b it=%0b v=%0b we=%0b d=%h a=%h w=%h exp all 0",
               dr, it, rq_v, rq_we, dout, rq_addr, rq_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad = 0;
    go_idle();
    repeat (20) begin
      @(negedge clk);
      if (dr || it || rq_v) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_local();
    local_req(0, 32'h10, 32'hDEAD_BEEF, 'x);
    local_req(1, 32'h10, 32'h0, 32'hDEAD_BEEF);
    local_req(1, 32'h13, 32'h0, 32'hDEAD_BEEF);
    local_req(0, EXT_BASE - 4, 32'hA5A5_0FF0, 'x);
    local_req(0, 32'h0, 32'h1111_2222, 'x);
    local_req(1, EXT_BASE - 1, 32'h0, 32'hA5A5_0FF0);
    local_req(1, 32'h0, 32'h0, 32'h1111_2222);
    local_req(0, 32'h4, 32'h0BAD_F00D, 'x);
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    @(posedge clk); #1;
    drive(AGU_LOAD, 32'h4, 32'h0);
    sb_q.push_back('{1'b1, 32'h0BAD_F00D});
    sb_q.push_back('{1'b1, 32'h0BAD_F00D});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = dr;
    end
    go_idle();
    vectors++;
    if (pat !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_pulses got %b exp 1010", pat);
    end
  endtask

  task automatic test_ext_load();
    int unstable = 0;
    int npulse = 0;
    int at = -1;
    rq_rdy = 1'b0;
    @(posedge clk); #1;
    drive(AGU_LOAD, EXT_BASE, 32'h0);
    sb_q.push_back('{1'b1, 32'h1234_5678});
    @(negedge clk);
    vectors++;
    if (rq_v !== 1'b0) begin
      errors++;
      $display("FAIL extld_early valid=%0b exp 0", rq_v);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (rq_v !== 1'b1 || rq_addr !== EXT_BASE || rq_we !== 1'b0)
        unstable++;
      if (i == 3) rq_rdy = 1'b1;
    end
    vectors++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL extld_stall got %0d bad cycles exp 0", unstable);
    end
    @(negedge clk);
    rq_rdy = 1'b0;
    vectors++;
    if (rq_v !== 1'b0) begin
      errors++;
      $display("FAIL extld_accept valid=%0b exp 0", rq_v);
    end
    repeat (3) begin
      @(negedge clk);
      if (dr) npulse++;
    end
    rs_v = 1'b1;
    rs_d = 32'h1234_5678;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rs_v = 1'b0;
        rs_d = 32'hFFFF_0000;
      end
      if (dr) begin
        npulse++;
        if (at < 0) at = k;
        go_idle();
      end
    end
    go_idle();
    vectors++;
    if (npulse != 1 || at != 0) begin
      errors++;
      $display("FAIL extld_pulse got count=%0d at=%0d exp count=1 at=0",
               npulse, at);
    end
  endtask

  task automatic test_ext_store();
    rq_rdy = 1'b1;
    @(posedge clk); #1;
    drive(AGU_STORE, 32'h8000_0000, 32'hCAFE_F00D);
    sb_q.push_back('{1'b0, 'x});
    @(negedge clk);
    vectors++;
    if (rq_v !== 1'b0) begin
      errors++;
      $display("FAIL extst_early valid=%0b exp 0", rq_v);
    end
    @(negedge clk);
    vectors++;
    if (rq_v !== 1'b1 || rq_we !== 1'b1 || src !== 8'(NODE) ||
        rq_addr !== 32'h8000_0000 || rq_wdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL extst_req got v=%0b we=%0b src=%0d a=%h w=%h exp 1 1 %0d 80000000 cafef00d",
               rq_v, rq_we, src, rq_addr, rq_wdata, NODE);
    end
    @(negedge clk);
    vectors++;
    if (it !== 1'b1) begin
      errors++;
      $display("FAIL extst_ack instrTaken=%0b exp 1", it);
    end
    go_idle();
    rq_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int bad = 0;
    rq_rdy = 1'b1;
    @(posedge clk); #1;
    drive(AGU_LOAD, 32'h4000_0000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rq_rdy = 1'b0;
    go_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rs_v = 1'b1;
    rs_d = 32'h5555_AAAA;
    vectors++;
    if (rq_v !== 1'b0 || dr !== 1'b0 || rq_addr !== '0) begin
      errors++;
      $display("FAIL rst_mid got v=%0b dr=%0b a=%h exp 0 0 0",
               rq_v, dr, rq_addr);
    end
    @(negedge clk);
    rs_v = 1'b0;
    repeat (3) begin
      if (dr || it || rq_v) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_stale_resp got %0d active cycles exp 0", bad);
    end
    local_req(1, 32'h10, 32'h0, 32'hDEAD_BEEF);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_local();
    test_back_to_back();
    test_ext_load();
    test_ext_store();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
